// File: rtl/block_data_memory_if.sv
// Block-granular request/response bundle between the data cache
// and the backing memory.
interface block_data_memory_if;
    logic        read;
    logic        write;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/block_data_memory.sv
// Slow 64 x 32-bit backing memory with a fixed access latency,
// serving one block per request over a busywait handshake.
module block_data_memory #(
    parameter int LATENCY = 5
) (
    input  logic               clock,
    input  logic               reset,
    block_data_memory_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    localparam logic [5:0] LOAD = 6'(LATENCY - 1);

    state_t      state;
    state_t      stateNext;
    logic [5:0]  counter;
    logic [5:0]  latchedAddress;
    logic [31:0] latchedData;
    logic        latchedWrite;
    logic [31:0] readData;
    logic        busy;
    logic        request;
    logic [31:0] memory [64];

    // read and write together is illegal and simply ignored
    assign request      = bus.read ^ bus.write;
    assign bus.busywait = busy;
    assign bus.readdata = readData;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = request;
                if (request) stateNext = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (counter == 6'd0) stateNext = ACK;
            end
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter        <= '0;
            latchedAddress <= '0;
            latchedData    <= '0;
            latchedWrite   <= 1'b0;
            readData       <= '0;
            for (int i = 0; i < 64; i++) memory[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (request) begin
                        latchedAddress <= bus.address;
                        latchedData    <= bus.writedata;
                        latchedWrite   <= bus.write;
                        counter        <= LOAD;
                    end
                end
                BUSY: begin
                    if (counter != 6'd0)
                        counter <= counter - 6'd1;
                    else if (latchedWrite)
                        memory[latchedAddress] <= latchedData;
                    else
                        readData <= memory[latchedAddress];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_block_data_memory.sv
// Randomised scoreboard bench for block_data_memory against an
// array-based memory model, plus directed reset/illegal/back-to-back cases.
module tb_block_data_memory;
    localparam int LAT = 5;

    typedef struct {
        logic        isRead;
        logic [31:0] data;
        int          doneEdge;
    } item_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] model [64];
    logic [31:0] modelRead;
    item_t       sb [$];

    block_data_memory_if bus ();
    block_data_memory_if busFast ();

    block_data_memory #(.LATENCY(LAT)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    block_data_memory #(.LATENCY(1)) dutFast (
        .clock(clock),
        .reset(reset),
        .bus  (busFast)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 64; i++) model[i] = '0;
        modelRead = '0;
        sb.delete();
    endtask

    // Monitor: the only state where a valid request meets busywait=0 is ACK
    initial begin
        item_t it;
        forever begin
            @(negedge clock);
            if (reset && (bus.read ^ bus.write) && !bus.busywait) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    it = sb.pop_front();
                    check("ack_edge", cyc, it.doneEdge);
                    check(it.isRead ? "readdata" : "readdata_hold",
                          bus.readdata, it.data);
                end
            end
        end
    end

    task automatic doAccess(logic isRead, logic [5:0] addr,
                            logic [31:0] data, logic perturb);
        item_t it;
        bit    done = 0;
        @(negedge clock);
        #1;
        bus.read      = isRead;
        bus.write     = !isRead;
        bus.address   = addr;
        bus.writedata = data;
        if (isRead) modelRead = model[addr];
        else        model[addr] = data;
        it.isRead   = isRead;
        it.data     = modelRead;
        it.doneEdge = cyc + 1 + LAT;
        sb.push_back(it);
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clock);
            #1;
            if (perturb && n == 1) begin
                bus.address   = 6'(addr + 6'd1);
                bus.writedata = '0;
            end
            if (!bus.busywait) done = 1;
        end
        if (!done) begin
            check("timeout", 32'd0, 32'd1);
            sb.delete();
        end
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    initial begin
        logic [5:0]  a;
        logic [31:0] d;
        bit          expSeq [5];
        reset = 1'b0;
        bus.read = 0; bus.write = 0; bus.address = '0; bus.writedata = '0;
        busFast.read = 0; busFast.write = 0;
        busFast.address = '0; busFast.writedata = '0;
        clearModel();

        repeat (2) @(negedge clock);
        check("reset_busywait", 32'(bus.busywait), 32'd0);
        check("reset_readdata", bus.readdata, 32'd0);
        #1 reset = 1'b1;

        doAccess(1, 6'h2A, '0, 0);
        doAccess(0, 6'h13, 32'hDEADBEEF, 0);
        doAccess(1, 6'h13, '0, 0);

        doAccess(0, 6'h13, 32'h55AA1234, 1);
        doAccess(1, 6'h13, '0, 0);
        doAccess(1, 6'h14, '0, 0);

        // Illegal: read and write together for 10 cycles
        @(negedge clock);
        #1;
        bus.read = 1; bus.write = 1;
        bus.address = 6'h13; bus.writedata = 32'h0BADF00D;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            check("illegal_busywait", 32'(bus.busywait), 32'd0);
        end
        check("illegal_readdata", bus.readdata, modelRead);
        #1;
        bus.read = 0; bus.write = 0;
        doAccess(1, 6'h13, '0, 0);

        for (int n = 0; n < 60; n++) begin
            a = 6'($urandom_range(0, 15));
            d = $urandom;
            doAccess(1'($urandom_range(0, 1)), a, d, 0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        doAccess(0, 6'h07, 32'hA0A0A0A0, 0);
        doAccess(1, 6'h07, '0, 0);

        // Reset abort on the 3rd BUSY cycle of a write to 7
        @(negedge clock);
        #1;
        bus.write = 1; bus.address = 6'h07; bus.writedata = 32'h12345678;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b0;
        clearModel();
        #1;
        check("abort_busywait_req", 32'(bus.busywait), 32'd1);
        check("abort_readdata", bus.readdata, 32'd0);
        bus.write = 0;
        #1;
        check("abort_busywait_idle", 32'(bus.busywait), 32'd0);
        @(negedge clock);
        #1 reset = 1'b1;
        doAccess(1, 6'h07, '0, 0);

        // Back-to-back with LATENCY = 1
        @(negedge clock);
        #1;
        busFast.write = 1; busFast.address = 6'h01;
        busFast.writedata = 32'hCAFEF00D;
        @(negedge clock);
        check("fast_wr_busy", 32'(busFast.busywait), 32'd1);
        @(negedge clock);
        check("fast_wr_ack", 32'(busFast.busywait), 32'd0);
        #1;
        busFast.write = 0;
        @(negedge clock);
        #1;
        busFast.read = 1;
        expSeq = '{1, 0, 1, 1, 0};
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            check($sformatf("fast_b2b_busy%0d", n),
                  32'(busFast.busywait), 32'(expSeq[n]));
            if (!expSeq[n])
                check("fast_b2b_data", busFast.readdata, 32'hCAFEF00D);
        end
        #1;
        busFast.read = 0;

        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clock);
        if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
